// File: rtl/control_flow_unit_l6_if.sv
// Micro-op encoding and the D->X / X->W / squash bundle for the control-flow execute unit.
// master = upstream/downstream environment view, slave = execute unit view.
package control_flow_unit_l6_pkg;
  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_BEQ  = 4'd2,
    OP_BNE  = 4'd3,
    OP_BLT  = 4'd4,
    OP_BGE  = 4'd5,
    OP_BLTU = 4'd6,
    OP_BGEU = 4'd7,
    OP_JAL  = 4'd8,
    OP_JALR = 4'd9
  } rv_uop;
endpackage

interface control_flow_unit_l6_if #(
  parameter int p_seq_num_bits   = 5,
  parameter int p_phys_addr_bits = 6
);
  import control_flow_unit_l6_pkg::*;

  logic                        D_val, D_rdy;
  logic [31:0]                 D_pc, D_op1, D_op2, D_op3;
  logic [p_seq_num_bits-1:0]   D_seq_num;
  logic [4:0]                  D_waddr;
  rv_uop                       D_uop;
  logic [p_phys_addr_bits-1:0] D_preg, D_ppreg;

  logic                        W_val, W_rdy;
  logic [31:0]                 W_pc, W_wdata;
  logic [p_seq_num_bits-1:0]   W_seq_num;
  logic [4:0]                  W_waddr;
  logic                        W_wen;
  logic [p_phys_addr_bits-1:0] W_preg, W_ppreg;

  logic                        squash_val;
  logic [31:0]                 squash_target;
  logic [p_seq_num_bits-1:0]   squash_seq_num;

  modport master (
    output D_val, D_pc, D_op1, D_op2, D_op3, D_seq_num, D_waddr, D_uop, D_preg, D_ppreg,
    input  D_rdy,
    input  W_val, W_pc, W_wdata, W_seq_num, W_waddr, W_wen, W_preg, W_ppreg,
    output W_rdy,
    input  squash_val, squash_target, squash_seq_num
  );

  modport slave (
    input  D_val, D_pc, D_op1, D_op2, D_op3, D_seq_num, D_waddr, D_uop, D_preg, D_ppreg,
    output D_rdy,
    output W_val, W_pc, W_wdata, W_seq_num, W_waddr, W_wen, W_preg, W_ppreg,
    input  W_rdy,
    output squash_val, squash_target, squash_seq_num
  );
endinterface

// File: rtl/control_flow_unit_l6.sv
// Control-flow execute unit: in-order op queue, branch/jump resolution at the head,
// one squash pulse per redirecting op, link value to writeback.
module control_flow_unit_l6
  import control_flow_unit_l6_pkg::*;
#(
  parameter int p_seq_num_bits   = 5,
  parameter int p_phys_addr_bits = 6,
  parameter int p_depth          = 2
) (
  input logic clk,
  input logic rst,
  control_flow_unit_l6_if.slave io
);
  localparam int PW = (p_depth > 1) ? $clog2(p_depth) : 1;
  localparam int CW = $clog2(p_depth + 1);

  typedef struct packed {
    logic [31:0]                 pc, op1, op2, op3;
    logic [p_seq_num_bits-1:0]   seq_num;
    logic [4:0]                  waddr;
    rv_uop                       uop;
    logic [p_phys_addr_bits-1:0] preg, ppreg;
  } entry_t;

  entry_t              q [p_depth];
  logic [p_depth-1:0]  vld;
  logic [PW-1:0]       head, tail;
  logic [CW-1:0]       count;
  logic                sent;
  logic                d_xfer, w_xfer, full, redirect, wen;
  logic [31:0]         target;
  entry_t              h;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(p_depth - 1)) ? '0 : p + PW'(1);
  endfunction

  assign h      = q[head];
  assign full   = (count == CW'(p_depth));
  assign w_xfer = io.W_val & io.W_rdy;
  assign d_xfer = io.D_val & io.D_rdy;

  assign io.D_rdy = ~full | w_xfer;
  assign io.W_val = vld[head];

  always_comb begin
    redirect = 1'b0;
    wen      = 1'b0;
    target   = h.pc + h.op3;
    case (h.uop)
      OP_BEQ:  redirect = (h.op1 == h.op2);
      OP_BNE:  redirect = (h.op1 != h.op2);
      OP_BLT:  redirect = ($signed(h.op1) <  $signed(h.op2));
      OP_BGE:  redirect = ($signed(h.op1) >= $signed(h.op2));
      OP_BLTU: redirect = (h.op1 <  h.op2);
      OP_BGEU: redirect = (h.op1 >= h.op2);
      OP_JAL:  wen = 1'b1;
      OP_JALR: begin
        redirect = 1'b1;
        wen      = 1'b1;
        target   = (h.op1 + h.op3) & ~32'h1;
      end
      default: ;
    endcase
  end

  assign io.W_pc           = h.pc;
  assign io.W_wdata        = h.pc + 32'd4;
  assign io.W_seq_num      = h.seq_num;
  assign io.W_waddr        = h.waddr;
  assign io.W_wen          = wen;
  assign io.W_preg         = h.preg;
  assign io.W_ppreg        = h.ppreg;
  assign io.squash_val     = io.W_val & redirect & ~sent;
  assign io.squash_target  = target;
  assign io.squash_seq_num = h.seq_num;

  // Payload storage carries no reset; validity is tracked separately.
  always_ff @(posedge clk) begin
    if (d_xfer)
      q[tail] <= '{pc: io.D_pc, op1: io.D_op1, op2: io.D_op2, op3: io.D_op3,
                   seq_num: io.D_seq_num, waddr: io.D_waddr, uop: io.D_uop,
                   preg: io.D_preg, ppreg: io.D_ppreg};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      vld   <= '0;
      sent  <= 1'b0;
    end else begin
      // Clear before set: on a full-queue bypass head==tail and the slot is refilled.
      if (w_xfer) begin
        vld[head] <= 1'b0;
        head      <= nxt(head);
      end
      if (d_xfer) begin
        vld[tail] <= 1'b1;
        tail      <= nxt(tail);
      end
      case ({d_xfer, w_xfer})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
      if (w_xfer)             sent <= 1'b0;
      else if (io.squash_val) sent <= 1'b1;
    end
  end
endmodule

// File: doc/control_flow_unit_l6.md
# control_flow_unit_l6

Parametrised successor execute unit for control-flow micro-ops. It resolves the full RV32I conditional-branch set (BEQ/BNE/BLT/BGE/BLTU/BGEU) plus JAL/JALR, and buffers accepted ops in a `p_depth`-entry in-order queue so the D→X handshake decouples from W back-pressure. It raises exactly one squash notification per redirecting op and sends the link value to writeback. It sits in X alongside the other L-series execute units, between the D__X and X__W interfaces.

## Interface
- `p_seq_num_bits`, 5, sequence-number width (taken from the D__X interface).
- `p_phys_addr_bits`, 6, physical-register tag width (taken from the D__X interface).
- `p_depth`, 2, number of queue entries; any integer ≥1.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `D_val` / `D_rdy`  in / out  1 / 1  D→X handshake.
- `D_pc`, `D_op1`, `D_op2`, `D_op3`  in  32 each  PC, rs1 value, rs2 value, immediate.
- `D_seq_num`  in  `p_seq_num_bits`  op sequence number.
- `D_waddr`  in  5  architectural destination register.
- `D_uop`  in  `rv_uop`  micro-op.
- `D_preg`, `D_ppreg`  in  `p_phys_addr_bits`  new and previous physical register tags.
- `W_val` / `W_rdy`  out / in  1 / 1  X→W handshake.
- `W_pc`, `W_wdata`  out  32  PC and link value.
- `W_seq_num`  out  `p_seq_num_bits`  sequence number.
- `W_waddr`  out  5  destination register.
- `W_wen`  out  1  register write enable.
- `W_preg`, `W_ppreg`  out  `p_phys_addr_bits`  passed-through tags.
- `squash_val`  out  1  squash notification valid.
- `squash_target`  out  32  redirect PC.
- `squash_seq_num`  out  `p_seq_num_bits`  sequence number of the redirecting op.

## Operation
- Circular queue: `p_depth` entries, head pointer, tail pointer and occupancy count (width clog2(`p_depth`+1)). Pointers wrap from `p_depth`-1 to 0. The queue must work for non-power-of-two depths.
- Enqueue (D_xfer = `D_val`&`D_rdy`): write the D fields at the tail.
- Dequeue (W_xfer = `W_val`&`W_rdy`): advance the head.
- `D_rdy` = !full | W_xfer. A same-cycle enqueue and dequeue on a full queue is legal; the count is unchanged.
- `W_val` = !empty. All W fields come combinationally from the head entry.
- Outcome per head uop (T = taken):
  - OP_BEQ: T = op1==op2.
  - OP_BNE: T = op1!=op2.
  - OP_BLT / OP_BGE: signed < / ≥.
  - OP_BLTU / OP_BGEU: unsigned < / ≥.
  - OP_JAL: no redirect (fetch already redirected).
  - OP_JALR: always redirects.
  - Any other uop: no redirect and `W_wen`=0. There are no X outputs.
- Targets use 32-bit modulo arithmetic:
  - Branch: pc+imm.
  - JALR: (op1+imm) & ~32'h1.
- `W_wen` is 1 for JAL/JALR and 0 otherwise. `W_wdata` = pc+4, mod 2^32.
- `squash_seq_num` and `squash_target` always reflect the head entry.
- Fire-once register `sent`:
  - `squash_val` = `W_val` & redirect & !`sent`.
  - `sent` sets on any cycle where `squash_val`=1 and W_xfer=0.
  - `sent` clears on W_xfer.
  - Result: each redirecting op asserts squash for exactly one cycle, which is its first cycle at the head, whether or not W stalls.
- Reset (async, `rst`=0):
  - Pointers, count and `sent` go to 0; all entries are marked invalid.
  - During and after reset, the outputs are `W_val`=0, `squash_val`=0, `D_rdy`=1.
  - Entry payloads need not reset. W data outputs are don't-care while `W_val`=0.
  - Reset asserted mid-operation drops all queued ops, and any pending squash is not issued.

## Timing
- Minimum latency is 1 cycle: an op accepted at edge N appears on W, and its squash if any, in the cycle after edge N.
- Throughput is one op per cycle when `W_rdy`=1, for any `p_depth`.
- `D_rdy` has a combinational dependence on `W_rdy`, only when the queue is full.
- A squash for the next head may assert in the same cycle the previous head dequeues; its `sent` starts at 0.
- Back-to-back redirecting ops each produce one squash pulse, in consecutive cycles if W never stalls.

## Test plan
- Reset: hold `rst`=0 for 3 cycles -> `W_val`=0, `squash_val`=0, `D_rdy`=1. Release reset -> no output activity until the first D_xfer.
- Branch coverage: BLT with op1=32'hFFFF_FFFF, op2=1, pc=0x100, imm=0x20 -> squash for 1 cycle, target 0x120, `W_wen`=0. Same operands as BLTU -> no squash.
- JALR: op1=0x2001, imm=4, pc=0x40, waddr=1 -> squash target 0x2004, `W_wen`=1, `W_wdata`=0x44.
- Fire-once under stall: taken BNE with `W_rdy`=0 for 5 cycles -> `squash_val` high only in the first cycle. Then `W_rdy`=1 -> dequeue with no second pulse.
- Full/bypass (`p_depth`=3): fill 3 ops with `W_rdy`=0 -> `D_rdy`=0. Then `W_rdy`=1 with `D_val`=1 -> `D_rdy`=1, count stays 3, W order matches D order, pointers wrap correctly.
- Reset mid-stream: 2 ops queued with a pending taken branch, then assert `rst` -> next cycle `W_val`=0, `squash_val`=0.
